// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_pkg
//  Purpose  : Shared types and helpers for the imem write-side loader:
//             loader state encoding, word geometry and big-endian byte-lane
//             selection (bit 0 of a word is its MSB, as in imem/dmem).
//  Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } load_state_t;

    // Byte lane idx of a [0:31] word; lane 0 is bits [0:7], the MSB byte, so
    // lanes written to a..a+3 read back as {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
    function automatic logic [0:7] byte_lane(input logic [0:31] word,
                                             input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Accepts a stream of 32-bit instruction words and writes each one
//             big-endian, one byte per cycle, into the imem byte array.
//             Checks alignment of the start address and the physical range of
//             every word before writing it.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned SIZE   = 4096,
    parameter logic [31:0] OFFSET = 32'h0000_0000,
    parameter int          CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [0:31]     base_addr,
    input  logic [CNTW-1:0] word_count,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:31]     in_word,
    output logic            wr_en,
    output logic [0:31]     wr_addr,
    output logic [0:7]      wr_data,
    output logic            busy,
    output logic            done,
    output logic            error
);

    // Highest legal physical byte address, widened so phys+3 cannot wrap.
    localparam logic [32:0] c_LAST_ADDR = 33'(SIZE) - 33'd1;

    load_state_t     r_state;
    logic [31:0]     r_phys;
    logic [CNTW-1:0] r_count;
    logic [1:0]      r_byte;
    logic [0:31]     r_word;

    logic [31:0]     w_phys_start;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_accept;
    logic [1:0]      w_next_byte;
    logic            w_last_word;

    // A logical address below OFFSET wraps to a huge physical address, which
    // the 33-bit range check below then rejects.
    assign w_phys_start   = base_addr - OFFSET;
    assign w_misaligned   = base_addr[30] | base_addr[31];
    assign w_out_of_range = ({1'b0, r_phys} + 33'd3) > c_LAST_ADDR;
    assign w_accept       = in_valid & in_ready;
    assign w_next_byte    = r_byte + 2'd1;
    assign w_last_word    = (r_count == CNTW'(1));

    // Load sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_phys   <= 32'd0;
            r_count  <= '0;
            r_byte   <= 2'd0;
            r_word   <= 32'd0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 32'd0;
            wr_data  <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_phys  <= w_phys_start;
                        r_count <= word_count;
                        if (w_misaligned) begin
                            r_state <= ST_ERR;
                            error   <= 1'b1;
                        end else if (word_count == '0) begin
                            r_state <= ST_DONE;
                            error   <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= ST_LOAD;
                            error    <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        in_ready <= 1'b0;
                        if (w_out_of_range) begin
                            // Word is dropped; nothing reaches the write port.
                            r_state <= ST_ERR;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            r_state <= ST_WRITE;
                            r_word  <= in_word;
                            r_byte  <= 2'd0;
                            wr_en   <= 1'b1;
                            wr_addr <= r_phys;
                            wr_data <= byte_lane(in_word, 2'd0);
                        end
                    end
                end

                ST_WRITE: begin
                    if (r_byte == 2'd3) begin
                        // Last lane is on the port this cycle; step to next word.
                        wr_en   <= 1'b0;
                        r_phys  <= r_phys + 32'(BYTES_PER_WORD);
                        r_count <= r_count - CNTW'(1);
                        if (w_last_word) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= ST_LOAD;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        r_byte  <= w_next_byte;
                        wr_addr <= r_phys + {30'd0, w_next_byte};
                        wr_data <= byte_lane(r_word, w_next_byte);
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                ST_ERR: begin
                    // error stays set until the next accepted start.
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    in_ready <= 1'b0;
                    wr_en    <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
